// File: rtl/miner_pkg.sv
// Shared constants and types for the multi-core miner control block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: slave address map, command codes, status codes, controller
// state encoding and a state-to-status helper.
package miner_pkg;

  // Slave word addresses
  localparam logic [4:0] ADDR_STATUS = 5'd0;
  localparam logic [4:0] ADDR_CTRL   = 5'd1;
  localparam logic [4:0] ADDR_TGT_LO = 5'd2;
  localparam logic [4:0] ADDR_TGT_HI = 5'd9;
  localparam logic [4:0] ADDR_NONCE  = 5'd10;
  localparam logic [4:0] ADDR_MSG_LO = 5'd11;
  localparam logic [4:0] ADDR_MSG_HI = 5'd29;
  localparam logic [4:0] ADDR_NSTART = 5'd30;
  localparam logic [4:0] ADDR_NLIMIT = 5'd31;

  localparam int TGT_WORDS = 8;   // 256-bit target
  localparam int MSG_WORDS = 19;  // 608-bit message

  // Control-register command codes
  localparam logic [31:0] CMD_LOAD_TGT = 32'd1;
  localparam logic [31:0] CMD_START    = 32'd2;
  localparam logic [31:0] CMD_ABORT    = 32'd4;

  // Status codes as seen at ADDR_STATUS
  typedef enum logic [2:0] {
    STAT_IDLE      = 3'd0,
    STAT_BUSY      = 3'd2,
    STAT_FOUND     = 3'd3,
    STAT_EXHAUSTED = 3'd4
  } status_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DISPATCH  = 3'd1,
    RUN       = 3'd2,
    FOUND     = 3'd3,
    EXHAUSTED = 3'd4
  } ctrl_state_t;

  // DISPATCH and RUN both report busy; software never sees the dispatch cycle.
  function automatic status_t status_of(input logic [2:0] st);
    case (st)
      DISPATCH, RUN: return STAT_BUSY;
      FOUND:         return STAT_FOUND;
      EXHAUSTED:     return STAT_EXHAUSTED;
      default:       return STAT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/miner_found_arbiter.sv
// Picks the lowest-index core reporting a hit and muxes out its nonce.
// Latency: combinational (0 cycles); the caller registers the result.
// Backpressure: none; hits are single-cycle pulses consumed immediately.
//
// Ports:
//   core_found  in  per-core hit pulse
//   core_nonce  in  per-core hit nonce, packed core 0 in the low bits
//   win_vld     out any core hit this cycle
//   win_idx     out index of the lowest hitting core
//   win_nonce   out nonce of that core
module miner_found_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  output logic                         win_vld,
  output logic [IDX_W-1:0]             win_idx,
  output logic [NONCE_W-1:0]           win_nonce
);

  // Scanning from the top down lets the lowest set index overwrite last.
  // Cores run in lockstep, so the lowest index also carries the lowest nonce.
  always_comb begin
    win_vld   = 1'b0;
    win_idx   = '0;
    win_nonce = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        win_vld   = 1'b1;
        win_idx   = IDX_W'(i);
        win_nonce = core_nonce[i*NONCE_W +: NONCE_W];
      end
    end
  end

endmodule

// File: rtl/multi_core_miner_ctrl.sv
// Register front end and search controller for NUM_CORES interleaved hash cores.
// Latency: writes/commands act at the sampling edge; read data 1 cycle after a read.
// Backpressure: none; the slave port accepts every access, cores get fire-and-forget pulses.
//
// Ports:
//   clk, n_rst                    clock, synchronous active-low reset
//   slaveAddr/WriteData/Write/Read/ChipSelect, slaveReadData   word-addressed slave port
//   core_target, core_msg         active search target and message (shared)
//   core_nonce_init, core_stride, core_limit   per-core nonce window setup
//   core_start, core_halt         one-cycle start (all cores) / stop pulses
//   core_found, core_nonce, core_exhausted     per-core results
module multi_core_miner_ctrl
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [4:0]                   slaveAddr,
  input  logic [31:0]                  slaveWriteData,
  input  logic                         slaveWrite,
  input  logic                         slaveRead,
  input  logic                         slaveChipSelect,
  output logic [31:0]                  slaveReadData,
  output logic [255:0]                 core_target,
  output logic [607:0]                 core_msg,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce_init,
  output logic [NONCE_W-1:0]           core_stride,
  output logic [NONCE_W-1:0]           core_limit,
  output logic [NUM_CORES-1:0]         core_start,
  output logic                         core_halt,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]         core_exhausted
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_DISPATCH  = DISPATCH;
  localparam logic [2:0] S_RUN       = RUN;
  localparam logic [2:0] S_FOUND     = FOUND;
  localparam logic [2:0] S_EXHAUSTED = EXHAUSTED;

  logic [2:0]                       state_q, state_d;
  logic                             halt_q, halt_d;
  logic [TGT_WORDS-1:0][31:0]       tgt_shadow_q, tgt_active_q;
  logic [MSG_WORDS-1:0][31:0]       msg_q, msg_active_q;
  logic [NONCE_W-1:0]               nstart_q, nlimit_q;
  logic [NONCE_W-1:0]               act_start_q, act_limit_q;
  logic [NONCE_W-1:0]               result_nonce_q;
  logic [7:0]                       win_core_q;
  logic [NUM_CORES-1:0]             exh_mask_q, exh_next;
  logic                             exh_done;
  logic [31:0]                      rdata_q, rd_mux;

  logic                             wr_en, rd_en, ctrl_wr;
  logic                             cmd_load_tgt, cmd_start, cmd_abort;
  logic                             start_ok;
  logic                             in_tgt, in_msg;
  logic [4:0]                       tgt_off, msg_off;

  logic                             arb_vld;
  logic [IDX_W-1:0]                 arb_idx;
  logic [NONCE_W-1:0]               arb_nonce;

  // ---------------------------------------------------------------------------
  // Slave decode
  // ---------------------------------------------------------------------------
  assign wr_en   = slaveChipSelect && slaveWrite;
  assign rd_en   = slaveChipSelect && slaveRead;
  assign ctrl_wr = wr_en && (slaveAddr == ADDR_CTRL);

  assign cmd_load_tgt = ctrl_wr && (slaveWriteData == CMD_LOAD_TGT);
  assign cmd_start    = ctrl_wr && (slaveWriteData == CMD_START);
  assign cmd_abort    = ctrl_wr && (slaveWriteData == CMD_ABORT);

  // A start is only honoured when no search is in flight.
  assign start_ok = cmd_start &&
                    ((state_q == S_IDLE) || (state_q == S_FOUND) || (state_q == S_EXHAUSTED));

  assign in_tgt  = (slaveAddr >= ADDR_TGT_LO) && (slaveAddr <= ADDR_TGT_HI);
  assign in_msg  = (slaveAddr >= ADDR_MSG_LO) && (slaveAddr <= ADDR_MSG_HI);
  assign tgt_off = slaveAddr - ADDR_TGT_LO;
  assign msg_off = slaveAddr - ADDR_MSG_LO;

  // ---------------------------------------------------------------------------
  // Hit arbitration
  // ---------------------------------------------------------------------------
  miner_found_arbiter #(
    .NUM_CORES (NUM_CORES),
    .NONCE_W   (NONCE_W),
    .IDX_W     (IDX_W)
  ) u_arb (
    .core_found (core_found),
    .core_nonce (core_nonce),
    .win_vld    (arb_vld),
    .win_idx    (arb_idx),
    .win_nonce  (arb_nonce)
  );

  // Include this cycle's pulses so the final exhausted core ends the run
  // at the same edge it is sampled.
  assign exh_next = exh_mask_q | core_exhausted;
  assign exh_done = &exh_next;

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    halt_d  = 1'b0;
    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (cmd_start) state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        // Empty window: cores were started but can never match, so stop them.
        if (act_limit_q < act_start_q) begin
          state_d = S_EXHAUSTED;
          halt_d  = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A hit outranks exhaustion and abort arriving in the same cycle.
        if (arb_vld) begin
          state_d = S_FOUND;
          halt_d  = 1'b1;
        end else if (exh_done) begin
          state_d = S_EXHAUSTED;
          halt_d  = 1'b1;
        end else if (cmd_abort) begin
          state_d = S_IDLE;
          halt_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    if (slaveAddr == ADDR_STATUS) begin
      rd_mux = {29'd0, status_of(state_q)};
    end else if (slaveAddr == ADDR_CTRL) begin
      rd_mux = {16'(NUM_CORES), win_core_q, 8'h00};
    end else if (slaveAddr == ADDR_NONCE) begin
      rd_mux[NONCE_W-1:0] = result_nonce_q;
    end else if (slaveAddr == ADDR_NSTART) begin
      rd_mux[NONCE_W-1:0] = nstart_q;
    end else if (slaveAddr == ADDR_NLIMIT) begin
      rd_mux[NONCE_W-1:0] = nlimit_q;
    end else if (in_tgt) begin
      rd_mux = tgt_shadow_q[tgt_off[2:0]];
    end else if (in_msg) begin
      rd_mux = msg_q[msg_off];
    end
  end

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      halt_q         <= 1'b0;
      tgt_shadow_q   <= '0;
      tgt_active_q   <= '0;
      msg_q          <= '0;
      msg_active_q   <= '0;
      nstart_q       <= '0;
      nlimit_q       <= '1;
      act_start_q    <= '0;
      act_limit_q    <= '1;
      result_nonce_q <= '0;
      win_core_q     <= '0;
      exh_mask_q     <= '0;
      rdata_q        <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;

      // Shadow/register copies follow writes at any time; active copies
      // only move on commands.
      if (wr_en) begin
        if (in_tgt)                    tgt_shadow_q[tgt_off[2:0]] <= slaveWriteData;
        if (in_msg)                    msg_q[msg_off]             <= slaveWriteData;
        if (slaveAddr == ADDR_NSTART)  nstart_q <= slaveWriteData[NONCE_W-1:0];
        if (slaveAddr == ADDR_NLIMIT)  nlimit_q <= slaveWriteData[NONCE_W-1:0];
      end

      if (cmd_load_tgt) tgt_active_q <= tgt_shadow_q;

      if (start_ok) begin
        msg_active_q <= msg_q;
        act_start_q  <= nstart_q;
        act_limit_q  <= nlimit_q;
      end

      if (state_q == S_DISPATCH) begin
        exh_mask_q <= '0;
      end else if (state_q == S_RUN) begin
        exh_mask_q <= exh_next;
      end

      if ((state_q == S_RUN) && arb_vld) begin
        result_nonce_q <= arb_nonce;
        win_core_q     <= 8'(arb_idx);
      end

      if (rd_en) rdata_q <= rd_mux;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    core_nonce_init = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_nonce_init[i*NONCE_W +: NONCE_W] = act_start_q + NONCE_W'(i);
    end
  end

  assign core_target   = tgt_active_q;
  assign core_msg      = msg_active_q;
  assign core_stride   = NONCE_W'(NUM_CORES);
  assign core_limit    = act_limit_q;
  assign core_start    = {NUM_CORES{state_q == S_DISPATCH}};
  assign core_halt     = halt_q;
  assign slaveReadData = rdata_q;

endmodule

// File: tb/tb_multi_core_miner_ctrl.sv
// Directed bench for multi_core_miner_ctrl: register table plus search sequences.
module tb_multi_core_miner_ctrl;

  localparam int NC = 4;
  localparam int NW = 32;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [4:0]        slaveAddr;
  logic [31:0]       slaveWriteData;
  logic              slaveWrite;
  logic              slaveRead;
  logic              slaveChipSelect;
  logic [31:0]       slaveReadData;
  logic [255:0]      core_target;
  logic [607:0]      core_msg;
  logic [NC*NW-1:0]  core_nonce_init;
  logic [NW-1:0]     core_stride;
  logic [NW-1:0]     core_limit;
  logic [NC-1:0]     core_start;
  logic              core_halt;
  logic [NC-1:0]     core_found;
  logic [NC*NW-1:0]  core_nonce;
  logic [NC-1:0]     core_exhausted;

  multi_core_miner_ctrl #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .slaveAddr       (slaveAddr),
    .slaveWriteData  (slaveWriteData),
    .slaveWrite      (slaveWrite),
    .slaveRead       (slaveRead),
    .slaveChipSelect (slaveChipSelect),
    .slaveReadData   (slaveReadData),
    .core_target     (core_target),
    .core_msg        (core_msg),
    .core_nonce_init (core_nonce_init),
    .core_stride     (core_stride),
    .core_limit      (core_limit),
    .core_start      (core_start),
    .core_halt       (core_halt),
    .core_found      (core_found),
    .core_nonce      (core_nonce),
    .core_exhausted  (core_exhausted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int halt_cnt = 0;

  // Count cycles in which the pulse outputs are high.
  always @(posedge clk) begin
    if (core_start != '0) start_cnt++;
    if (core_halt)        halt_cnt++;
  end

  typedef struct {
    logic        is_wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    slaveAddr       = a;
    slaveWriteData  = d;
    slaveWrite      = 1'b1;
    slaveChipSelect = 1'b1;
    tick();
    slaveWrite      = 1'b0;
    slaveChipSelect = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    slaveAddr       = a;
    slaveRead       = 1'b1;
    slaveChipSelect = 1'b1;
    tick();
    slaveRead       = 1'b0;
    slaveChipSelect = 1'b0;
    check(name, {32'd0, slaveReadData}, {32'd0, exp});
  endtask

  task automatic set_nonce(input int core, input logic [31:0] v);
    core_nonce[core*NW +: NW] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [607:0]     exp_msg;
    logic [127:0]     exp_init;
    int               s0, h0;
    int               order [4];

    n_rst           = 1'b0;
    slaveAddr       = '0;
    slaveWriteData  = '0;
    slaveWrite      = 1'b0;
    slaveRead       = 1'b0;
    slaveChipSelect = 1'b0;
    core_found      = '0;
    core_nonce      = '0;
    core_exhausted  = '0;

    // ---------------- reset ----------------
    tick();
    tick();
    n_rst = 1'b1;
    check("rst_core_start",  {60'd0, core_start}, 64'd0);
    check("rst_core_halt",   {63'd0, core_halt}, 64'd0);
    check("rst_core_limit",  {32'd0, core_limit}, 64'hFFFF_FFFF);
    check("rst_core_stride", {32'd0, core_stride}, 64'd4);
    check("rst_target_zero", {63'd0, core_target == 256'd0}, 64'd1);
    check("rst_readdata",    {32'd0, slaveReadData}, 64'd0);
    read_check("rst_status", 5'd0, 32'h0);
    read_check("rst_nlimit", 5'd31, 32'hFFFF_FFFF);
    read_check("rst_ctrl",   5'd1, 32'h0004_0000);

    // ---------------- register table ----------------
    vecs[0]  = '{1'b1, 5'd2,  32'h1111_2222, 32'h0};
    vecs[1]  = '{1'b0, 5'd2,  32'h0,         32'h1111_2222};
    vecs[2]  = '{1'b1, 5'd9,  32'hCAFE_0009, 32'h0};
    vecs[3]  = '{1'b0, 5'd9,  32'h0,         32'hCAFE_0009};
    vecs[4]  = '{1'b1, 5'd11, 32'h0BAD_F00D, 32'h0};
    vecs[5]  = '{1'b0, 5'd11, 32'h0,         32'h0BAD_F00D};
    vecs[6]  = '{1'b1, 5'd29, 32'h2929_2929, 32'h0};
    vecs[7]  = '{1'b0, 5'd29, 32'h0,         32'h2929_2929};
    vecs[8]  = '{1'b1, 5'd30, 32'h0000_0005, 32'h0};
    vecs[9]  = '{1'b0, 5'd30, 32'h0,         32'h0000_0005};
    vecs[10] = '{1'b1, 5'd31, 32'h0000_0009, 32'h0};
    vecs[11] = '{1'b0, 5'd31, 32'h0,         32'h0000_0009};
    vecs[12] = '{1'b1, 5'd0,  32'h0000_FFFF, 32'h0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         32'h0};
    vecs[14] = '{1'b1, 5'd10, 32'h0000_1234, 32'h0};
    vecs[15] = '{1'b0, 5'd10, 32'h0,         32'h0};
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].data);
      else read_check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end
    check("msg_not_active_before_start", {63'd0, core_msg == 608'd0}, 64'd1);

    // ---------------- single hit ----------------
    for (int a = 2; a <= 8; a++) bus_write(5'(a), 32'h0);
    bus_write(5'd9, 32'h1000_0000);
    check("target_before_load", {63'd0, core_target == 256'd0}, 64'd1);
    bus_write(5'd1, 32'd1);
    check("target_loaded", {63'd0, core_target == {32'h1000_0000, 224'd0}}, 64'd1);
    exp_msg = '0;
    for (int k = 0; k < 19; k++) begin
      exp_msg[k*32 +: 32] = 32'hA000_0000 + 32'(k);
      bus_write(5'(11 + k), 32'hA000_0000 + 32'(k));
    end
    bus_write(5'd30, 32'h0);
    bus_write(5'd31, 32'hFFFF_FFFF);
    s0 = start_cnt;
    h0 = halt_cnt;
    bus_write(5'd1, 32'd2);
    check("hit_core_start_on", {60'd0, core_start}, 64'hF);
    exp_init = {32'd3, 32'd2, 32'd1, 32'd0};
    check("hit_nonce_init", {63'd0, core_nonce_init == exp_init}, 64'd1);
    check("hit_msg_latched", {63'd0, core_msg == exp_msg}, 64'd1);
    check("hit_core_limit", {32'd0, core_limit}, 64'hFFFF_FFFF);
    tick();
    check("hit_core_start_off", {60'd0, core_start}, 64'd0);
    read_check("hit_status_busy", 5'd0, 32'd2);
    core_found = 4'b0100;
    set_nonce(2, 32'd42);
    tick();
    core_found = '0;
    check("hit_halt_on", {63'd0, core_halt}, 64'd1);
    tick();
    check("hit_halt_off", {63'd0, core_halt}, 64'd0);
    check("hit_halt_pulses", 64'(halt_cnt - h0), 64'd1);
    check("hit_start_pulses", 64'(start_cnt - s0), 64'd1);
    read_check("hit_status_found", 5'd0, 32'd3);
    read_check("hit_result_nonce", 5'd10, 32'd42);
    read_check("hit_win_core", 5'd1, 32'h0004_0200);

    // ---------------- simultaneous hits ----------------
    bus_write(5'd1, 32'd2);
    tick();
    core_found = 4'b1010;
    set_nonce(0, 32'd99);
    set_nonce(1, 32'd13);
    set_nonce(2, 32'd77);
    set_nonce(3, 32'd15);
    tick();
    core_found = '0;
    read_check("multi_result_nonce", 5'd10, 32'd13);
    read_check("multi_win_core", 5'd1, 32'h0004_0100);
    read_check("multi_status", 5'd0, 32'd3);

    // ---------------- exhaustion ----------------
    bus_write(5'd30, 32'd100);
    bus_write(5'd31, 32'd107);
    h0 = halt_cnt;
    bus_write(5'd1, 32'd2);
    exp_init = {32'd103, 32'd102, 32'd101, 32'd100};
    check("exh_nonce_init", {63'd0, core_nonce_init == exp_init}, 64'd1);
    check("exh_core_limit", {32'd0, core_limit}, 64'd107);
    tick();
    order = '{0, 3, 1, 2};
    for (int j = 0; j < 4; j++) begin
      core_exhausted = '0;
      core_exhausted[order[j]] = 1'b1;
      tick();
      core_exhausted = '0;
      read_check($sformatf("exh_status_after_bit%0d", order[j]), 5'd0, (j == 3) ? 32'd4 : 32'd2);
    end
    check("exh_halt_pulses", 64'(halt_cnt - h0), 64'd1);

    // ---------------- empty window ----------------
    bus_write(5'd30, 32'd10);
    bus_write(5'd31, 32'd5);
    s0 = start_cnt;
    h0 = halt_cnt;
    bus_write(5'd1, 32'd2);
    check("empty_core_start", {60'd0, core_start}, 64'hF);
    tick();
    check("empty_halt_on", {63'd0, core_halt}, 64'd1);
    read_check("empty_status", 5'd0, 32'd4);
    check("empty_start_pulses", 64'(start_cnt - s0), 64'd1);
    check("empty_halt_pulses", 64'(halt_cnt - h0), 64'd1);

    // ---------------- found and exhausted together ----------------
    bus_write(5'd30, 32'h0);
    bus_write(5'd31, 32'hFFFF_FFFF);
    bus_write(5'd1, 32'd2);
    tick();
    core_found     = 4'b0001;
    core_exhausted = 4'hF;
    set_nonce(0, 32'd7);
    tick();
    core_found     = '0;
    core_exhausted = '0;
    read_check("fe_status", 5'd0, 32'd3);
    read_check("fe_result_nonce", 5'd10, 32'd7);

    // ---------------- abort and found together ----------------
    bus_write(5'd1, 32'd2);
    tick();
    core_found = 4'b1000;
    set_nonce(3, 32'h55);
    bus_write(5'd1, 32'd4);
    core_found = '0;
    read_check("af_status", 5'd0, 32'd3);
    read_check("af_result_nonce", 5'd10, 32'h55);
    read_check("af_win_core", 5'd1, 32'h0004_0300);

    // ---------------- abort and restart ----------------
    bus_write(5'd1, 32'd2);
    tick();
    h0 = halt_cnt;
    bus_write(5'd1, 32'd4);
    read_check("abort_status", 5'd0, 32'd0);
    check("abort_halt_pulses", 64'(halt_cnt - h0), 64'd1);
    s0 = start_cnt;
    bus_write(5'd1, 32'd2);
    tick();
    bus_write(5'd1, 32'd2);
    tick();
    check("restart_start_pulses", 64'(start_cnt - s0), 64'd1);
    read_check("restart_status", 5'd0, 32'd2);

    // ---------------- mid-run writes ----------------
    bus_write(5'd11, 32'hDEAD_BEEF);
    bus_write(5'd9, 32'hFFFF_FFFF);
    bus_write(5'd30, 32'h0000_1000);
    check("midrun_msg_held", {63'd0, core_msg == exp_msg}, 64'd1);
    check("midrun_target_held", {63'd0, core_target == {32'h1000_0000, 224'd0}}, 64'd1);
    check("midrun_init_held", {32'd0, core_nonce_init[31:0]}, 64'd0);
    read_check("midrun_msg_shadow", 5'd11, 32'hDEAD_BEEF);
    bus_write(5'd1, 32'd4);
    bus_write(5'd1, 32'd2);
    exp_msg[31:0] = 32'hDEAD_BEEF;
    check("restart_msg_new", {63'd0, core_msg == exp_msg}, 64'd1);
    check("restart_init_new", {32'd0, core_nonce_init[31:0]}, 64'h1000);

    // ---------------- reset mid-run ----------------
    tick();
    h0 = halt_cnt;
    n_rst = 1'b0;
    tick();
    check("rstrun_core_start", {60'd0, core_start}, 64'd0);
    check("rstrun_core_halt", {63'd0, core_halt}, 64'd0);
    check("rstrun_msg_zero", {63'd0, core_msg == 608'd0}, 64'd1);
    check("rstrun_core_limit", {32'd0, core_limit}, 64'hFFFF_FFFF);
    n_rst = 1'b1;
    read_check("rstrun_status", 5'd0, 32'd0);
    read_check("rstrun_nlimit", 5'd31, 32'hFFFF_FFFF);
    read_check("rstrun_nstart", 5'd30, 32'd0);
    check("rstrun_no_halt", 64'(halt_cnt - h0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
